uart_tx_ext: RTL and testbench
==============================

UART_TX_EXT -- requirements
Module: uart_tx_ext

Interface
REQ-001 Parameter UART_DATA_WIDTH, default 8, maximum data bits per frame and width of i_Tx_Byte.
REQ-002 Parameter CONFIG_DATA_WIDTH, default 32, width of uart_config_data and the bit-period counter.
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, at least 2.
REQ-004 i_Clock  input  1  sole clock; all logic on rising edge.
REQ-005 i_Reset  input  1  synchronous, active-high reset.
REQ-006 uart_config_data  input  CONFIG_DATA_WIDTH  clocks per bit.
REQ-007 i_Data_Bits  input  clog2(UART_DATA_WIDTH+1)  data bits per frame.
REQ-008 i_Parity_Mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-009 i_Stop_Bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 i_Tx_DV  input  1  write strobe for i_Tx_Byte.
REQ-011 i_Tx_Byte  input  UART_DATA_WIDTH  data to queue, LSB sent first.
REQ-012 o_Tx_Ready  output  1  FIFO not full.
REQ-013 o_Tx_Overrun  output  1  one-cycle pulse when a write is dropped.
REQ-014 o_Fifo_Count  output  clog2(FIFO_DEPTH+1)  queued entries.
REQ-015 o_Tx_Active  output  1  frame on line.
REQ-016 o_Tx_Serial  output  1  serial line, registered, idle high.
REQ-017 o_Tx_Done  output  1  one-cycle pulse at end of each frame.

Function
REQ-018 FIFO write SHALL occur when i_Tx_DV=1 and o_Tx_Ready=1; if i_Tx_DV=1 and o_Tx_Ready=0, data SHALL be dropped and o_Tx_Overrun SHALL pulse for one cycle on the following cycle.
REQ-019 o_Tx_Ready SHALL be derived from the registered count; a write while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-020 A simultaneous push and pop with the FIFO not full SHALL leave o_Fifo_Count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 States: IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE: o_Tx_Serial=1; if count>0, pop the head entry, latch it with uart_config_data, i_Data_Bits, i_Parity_Mode and i_Stop_Bits, and go to START.
REQ-023 Configuration changes during a frame SHALL have no effect until the next pop.
REQ-024 Bit period SHALL be exactly uart_config_data cycles; value 0 SHALL be treated as 1.
REQ-025 i_Data_Bits of 0 or greater than UART_DATA_WIDTH SHALL be treated as UART_DATA_WIDTH.
REQ-026 START drives 0 for one bit period and goes to DATA; DATA sends the latched bits LSB first, one bit period each.
REQ-027 After the last data bit, go to PARITY if the mode is even or odd, otherwise go to STOP.
REQ-028 The parity bit SHALL be the XOR of the transmitted data bits for even mode and its inverse for odd mode; upper unused bits are excluded.
REQ-029 STOP drives 1 for one or two bit periods.
REQ-030 At the final cycle of STOP: pulse o_Tx_Done; if count>0, pop and go directly to START, with no idle cycle between frames; otherwise go to IDLE.
REQ-031 o_Tx_Active SHALL be 1 from the first start-bit cycle through the last stop-bit cycle, and SHALL remain continuous across back-to-back frames.
REQ-032 Latency: a write in cycle N into an empty FIFO with the block IDLE SHALL drive o_Tx_Serial low starting cycle N+2.

Reset
REQ-033 Reset SHALL force o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Overrun=0, o_Fifo_Count=0 and o_Tx_Ready=1, and SHALL set the state to IDLE.
REQ-034 Reset mid-frame SHALL abort the frame, discard FIFO contents, and suppress o_Tx_Done; the line SHALL be high on the cycle after reset is sampled.
REQ-035 i_Tx_DV during reset SHALL be ignored.

Verification
REQ-036 uart_config_data=4, 8N1, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total, one o_Tx_Done pulse, o_Tx_Active high for 40 cycles.
REQ-037 uart_config_data=2, 7 bits, even parity, 2 stop bits, write 0x35 -> line 0,1,0,1,0,1,1,0, parity 0, then 1,1, 11 bits total.
REQ-038 8 bits, odd parity, write 0xFF -> parity bit 1; the same frame in even mode -> parity bit 0.
REQ-039 FIFO_DEPTH=4, writes on 6 consecutive cycles from IDLE -> 5 accepted and 6th dropped with an o_Tx_Overrun pulse; 5 frames back-to-back with no idle gap; 5 o_Tx_Done pulses; o_Tx_Active continuous.
REQ-040 Reset asserted during data bit 3 with 2 bytes queued -> next cycle o_Tx_Serial=1, o_Tx_Active=0, o_Fifo_Count=0; no o_Tx_Done pulse and no further frames.
REQ-041 uart_config_data=0, 5 bits, no parity, write 0x1F -> 7-cycle frame 0,1,1,1,1,1,1.

Source files
------------

// File: rtl/uart_tx_ext.sv
// UART transmitter with a small transmit FIFO and per-frame configuration.
// Each frame latches bit period, data width, parity and stop bits when its
// byte is popped, so the line format can only change between frames.
module uart_tx_ext #(
   parameter int UART_DATA_WIDTH   = 8,
   parameter int CONFIG_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                                 i_Clock,
   input  logic                                 i_Reset,
   input  logic [CONFIG_DATA_WIDTH-1:0]         uart_config_data,
   input  logic [$clog2(UART_DATA_WIDTH+1)-1:0] i_Data_Bits,
   input  logic [1:0]                           i_Parity_Mode,
   input  logic                                 i_Stop_Bits,
   input  logic                                 i_Tx_DV,
   input  logic [UART_DATA_WIDTH-1:0]           i_Tx_Byte,
   output logic                                 o_Tx_Ready,
   output logic                                 o_Tx_Overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_Fifo_Count,
   output logic                                 o_Tx_Active,
   output logic                                 o_Tx_Serial,
   output logic                                 o_Tx_Done
);
   localparam int W    = UART_DATA_WIDTH;
   localparam int CW   = CONFIG_DATA_WIDTH;
   localparam int DBW  = $clog2(UART_DATA_WIDTH+1);
   localparam int CNTW = $clog2(FIFO_DEPTH+1);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam logic [CNTW-1:0] FULL = CNTW'(FIFO_DEPTH);
   localparam logic [DBW-1:0]  MAXB = DBW'(UART_DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [W-1:0]    mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            overrun;

   state_t          state;
   logic [CW-1:0]   period_r, clk_cnt;
   logic [W-1:0]    sh_r;
   logic [DBW-1:0]  nbits_r, bit_idx;
   logic            par_en_r, par_bit_r, stop2_r, tx_serial;

   logic            push, pop, bit_end, stop_end, par_next;
   logic [W-1:0]    head;
   logic [DBW-1:0]  nb_eff;

   // Ready comes from the registered count only, so a write while full is
   // dropped even if a pop frees a slot in the same cycle.
   assign o_Tx_Ready   = (count != FULL);
   assign o_Fifo_Count = count;
   assign o_Tx_Overrun = overrun;
   assign o_Tx_Serial  = tx_serial;
   assign o_Tx_Active  = (state != IDLE);
   assign push     = i_Tx_DV && o_Tx_Ready && !i_Reset;
   assign bit_end  = (clk_cnt == period_r - CW'(1));
   // Last cycle of the last stop bit; the second stop bit is bit_idx 1.
   assign stop_end = (state == STOP) && bit_end && (!stop2_r || bit_idx[0]);
   assign o_Tx_Done = stop_end;
   assign pop      = !i_Reset && (count != '0) && ((state == IDLE) || stop_end);
   assign head     = mem[rd_ptr];

   // Effective data width and parity of the head entry, computed at pop time.
   always_comb begin
      logic acc;
      nb_eff = (i_Data_Bits == '0 || i_Data_Bits > MAXB) ? MAXB : i_Data_Bits;
      acc = 1'b0;
      for (int i = 0; i < W; i++)
         if (i < int'(nb_eff)) acc = acc ^ head[i];
      par_next = acc ^ (i_Parity_Mode == 2'b10);
   end

   // FIFO storage; entries need no reset since count gates every read.
   always_ff @(posedge i_Clock) begin
      if (push) mem[wr_ptr] <= i_Tx_Byte;
   end

   // FIFO pointers, occupancy and the dropped-write pulse.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= i_Tx_DV && !o_Tx_Ready;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // Frame sequencer; the serial bit is registered alongside the state.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state     <= IDLE;
         tx_serial <= 1'b1;
         clk_cnt   <= '0;
         period_r  <= CW'(1);
         bit_idx   <= '0;
         nbits_r   <= MAXB;
         sh_r      <= '0;
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
         stop2_r   <= 1'b0;
      end else if (pop) begin
         state     <= START;
         tx_serial <= 1'b0;
         clk_cnt   <= '0;
         period_r  <= (uart_config_data == '0) ? CW'(1) : uart_config_data;
         bit_idx   <= '0;
         nbits_r   <= nb_eff;
         sh_r      <= head;
         par_en_r  <= (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
         par_bit_r <= par_next;
         stop2_r   <= i_Stop_Bits;
      end else begin
         if (state != IDLE) clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
         if (bit_end) begin
            case (state)
               START: begin
                  state     <= DATA;
                  bit_idx   <= '0;
                  tx_serial <= sh_r[0];
               end
               DATA: begin
                  if (bit_idx == nbits_r - DBW'(1)) begin
                     bit_idx <= '0;
                     if (par_en_r) begin
                        state     <= PARITY;
                        tx_serial <= par_bit_r;
                     end else begin
                        state     <= STOP;
                        tx_serial <= 1'b1;
                     end
                  end else begin
                     bit_idx   <= bit_idx + DBW'(1);
                     sh_r      <= sh_r >> 1;
                     tx_serial <= sh_r[1];
                  end
               end
               PARITY: begin
                  state     <= STOP;
                  bit_idx   <= '0;
                  tx_serial <= 1'b1;
               end
               STOP: begin
                  if (stop_end) begin
                     state     <= IDLE;
                     tx_serial <= 1'b1;
                  end else begin
                     bit_idx <= DBW'(1);
                  end
               end
               default: tx_serial <= 1'b1;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_ext.sv
// Self-checking bench for uart_tx_ext. Expected line waveforms are built
// from frame rules (start, data LSB first, parity, stop bits, each repeated
// for the bit period) and compared cycle by cycle against a capture.
module tb_uart_tx_ext;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, dv, stop2;
   logic [31:0] cfg;
   logic [3:0]  dbits;
   logic [1:0]  pmode;
   logic [7:0]  txb;
   logic        rdy, ovr, act, ser, done;
   logic [2:0]  cnt;

   uart_tx_ext #(.UART_DATA_WIDTH(8), .CONFIG_DATA_WIDTH(32), .FIFO_DEPTH(4)) uut (
      .i_Clock(clk), .i_Reset(rst), .uart_config_data(cfg), .i_Data_Bits(dbits),
      .i_Parity_Mode(pmode), .i_Stop_Bits(stop2), .i_Tx_DV(dv), .i_Tx_Byte(txb),
      .o_Tx_Ready(rdy), .o_Tx_Overrun(ovr), .o_Fifo_Count(cnt), .o_Tx_Active(act),
      .o_Tx_Serial(ser), .o_Tx_Done(done));

   int passed = 0, total = 0;
   bit cap_en = 1'b0;
   logic c_ser[$], c_act[$], c_done[$], c_ovr[$], c_rdy[$];
   logic [2:0] c_cnt[$];
   logic e_ser[$], e_act[$], e_done[$], e_ovr[$];

   always @(negedge clk) if (cap_en) begin
      c_ser.push_back(ser); c_act.push_back(act); c_done.push_back(done);
      c_ovr.push_back(ovr); c_rdy.push_back(rdy); c_cnt.push_back(cnt);
   end

   task automatic step(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic cap_start();
      c_ser.delete(); c_act.delete(); c_done.delete();
      c_ovr.delete(); c_rdy.delete(); c_cnt.delete();
      cap_en = 1'b1;
   endtask

   task automatic set_cfg(int c, int nb, int mode, bit s2);
      cfg = c; dbits = 4'(nb); pmode = 2'(mode); stop2 = s2;
   endtask

   task automatic write_burst(input logic [7:0] q[$]);
      foreach (q[i]) begin dv = 1'b1; txb = q[i]; step(1); end
      dv = 1'b0;
   endtask

   // Reference model: the two cycles of write latency, then whole frames.
   function automatic void exp_idle(int n);
      for (int i = 0; i < n; i++) begin
         e_ser.push_back(1'b1); e_act.push_back(1'b0);
         e_done.push_back(1'b0); e_ovr.push_back(1'b0);
      end
   endfunction

   function automatic void exp_init();
      e_ser.delete(); e_act.delete(); e_done.delete(); e_ovr.delete();
      exp_idle(2);
   endfunction

   function automatic void exp_frame(logic [7:0] b, int c, int nb, int mode, bit s2);
      bit bits[$];
      bit ones = 1'b0;
      int p = (c == 0) ? 1 : c;
      int n = (nb == 0 || nb > 8) ? 8 : nb;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin bits.push_back(b[i]); ones ^= b[i]; end
      if (mode == 1) bits.push_back(ones);
      if (mode == 2) bits.push_back(!ones);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      foreach (bits[j])
         for (int k = 0; k < p; k++) begin
            e_ser.push_back(bits[j]); e_act.push_back(1'b1); e_ovr.push_back(1'b0);
            e_done.push_back((j == bits.size() - 1) && (k == p - 1));
         end
   endfunction

   task automatic test_reset();
      rst = 1'b1; dv = 1'b1; txb = 8'h55;
      step(2);
      total++;
      if ({ser, act, done, ovr, rdy, cnt} !== 8'b1000_1000)
         $display("FAIL reset_hold ser/act/done/ovr/rdy/cnt got %b want 10001000",
                  {ser, act, done, ovr, rdy, cnt});
      else passed++;
      rst = 1'b0; dv = 1'b0;
      step(3);
      total++;
      if ({ser, act, done, ovr, rdy, cnt} !== 8'b1000_1000)
         $display("FAIL reset_after ser/act/done/ovr/rdy/cnt got %b want 10001000",
                  {ser, act, done, ovr, rdy, cnt});
      else passed++;
   endtask

   task automatic test_8n1();
      logic [7:0] q[$] = '{8'hA5};
      int dones = 0, acts = 0;
      set_cfg(4, 8, 0, 1'b0);
      exp_init(); exp_frame(8'hA5, 4, 8, 0, 1'b0); exp_idle(4);
      cap_start(); write_burst(q); step(e_ser.size() - 1); cap_en = 1'b0;
      for (int i = 0; i < e_ser.size(); i++) begin
         total++;
         if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
            $display("FAIL 8n1 cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", i,
                     c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
         else passed++;
         if (c_done[i] === 1'b1) dones++;
         if (c_act[i] === 1'b1) acts++;
      end
      total++;
      if (dones != 1 || acts != 40)
         $display("FAIL 8n1_totals done pulses %0d active cycles %0d want 1 and 40", dones, acts);
      else passed++;
   endtask

   task automatic test_7e2();
      logic [7:0] q[$] = '{8'h35};
      set_cfg(2, 7, 1, 1'b1);
      exp_init(); exp_frame(8'h35, 2, 7, 1, 1'b1); exp_idle(4);
      total++;
      if (e_ser.size() != 2 + 22 + 4) $display("FAIL 7e2_len model %0d want 28", e_ser.size());
      else passed++;
      cap_start(); write_burst(q); step(e_ser.size() - 1); cap_en = 1'b0;
      for (int i = 0; i < e_ser.size(); i++) begin
         total++;
         if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
            $display("FAIL 7e2 cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", i,
                     c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
         else passed++;
      end
   endtask

   task automatic test_parity();
      logic [7:0] q[$] = '{8'hFF};
      for (int m = 1; m <= 2; m++) begin
         set_cfg(2, 8, m, 1'b0);
         exp_init(); exp_frame(8'hFF, 2, 8, m, 1'b0); exp_idle(3);
         cap_start(); write_burst(q); step(e_ser.size() - 1); cap_en = 1'b0;
         total++;
         // parity bit occupies bit slot 9 -> cycles 2+18, 2+19
         if (c_ser[20] !== (m == 2))
            $display("FAIL parity_bit mode %0d got %b want %b", m, c_ser[20], (m == 2));
         else passed++;
         for (int i = 0; i < e_ser.size(); i++) begin
            total++;
            if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
               $display("FAIL parity cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", i,
                        c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
            else passed++;
         end
      end
   endtask

   task automatic test_cfg0();
      logic [7:0] q[$] = '{8'h1F};
      set_cfg(0, 5, 0, 1'b0);
      exp_init(); exp_frame(8'h1F, 0, 5, 0, 1'b0); exp_idle(3);
      cap_start(); write_burst(q); step(e_ser.size() - 1); cap_en = 1'b0;
      for (int i = 0; i < e_ser.size(); i++) begin
         total++;
         if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
            $display("FAIL cfg0 cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", i,
                     c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
         else passed++;
      end
   endtask

   task automatic test_overflow();
      logic [7:0] q[$];
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
      set_cfg(2, 8, 0, 1'b0);
      exp_init();
      for (int i = 0; i < 5; i++) exp_frame(q[i], 2, 8, 0, 1'b0);
      exp_idle(4);
      e_ovr[6] = 1'b1;
      cap_start(); write_burst(q); step(e_ser.size() - 6); cap_en = 1'b0;
      total++;
      if (c_rdy[5] !== 1'b0 || c_cnt[5] !== 3'd4 || c_cnt[6] !== 3'd4)
         $display("FAIL overflow_full rdy %b cnt %0d/%0d want 0 and 4/4", c_rdy[5], c_cnt[5], c_cnt[6]);
      else passed++;
      for (int i = 0; i < e_ser.size(); i++) begin
         total++;
         if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
            $display("FAIL overflow cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", i,
                     c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
         else passed++;
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] q[$];
      for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
      set_cfg(4, 8, 0, 1'b0);
      exp_init(); exp_frame(q[0], 4, 8, 0, 1'b0);
      while (e_ser.size() > 20) begin
         void'(e_ser.pop_back()); void'(e_act.pop_back());
         void'(e_done.pop_back()); void'(e_ovr.pop_back());
      end
      exp_idle(60);
      cap_start(); write_burst(q); step(16);
      rst = 1'b1; dv = 1'b1; txb = 8'($urandom);
      step(1);
      rst = 1'b0; dv = 1'b0;
      step(60); cap_en = 1'b0;
      total++;
      if (c_cnt[19] !== 3'd2 || c_cnt[20] !== 3'd0 || c_rdy[20] !== 1'b1)
         $display("FAIL reset_mid_fifo cnt %0d->%0d rdy %b want 2->0 rdy 1", c_cnt[19], c_cnt[20], c_rdy[20]);
      else passed++;
      for (int i = 0; i < e_ser.size(); i++) begin
         total++;
         if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
            $display("FAIL reset_mid cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", i,
                     c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
         else passed++;
      end
   endtask

   task automatic test_cfg_change();
      logic [7:0] q[$];
      q.push_back(8'($urandom));
      set_cfg(3, 8, 1, 1'b0);
      exp_init(); exp_frame(q[0], 3, 8, 1, 1'b0); exp_idle(4);
      cap_start(); write_burst(q); step(2);
      set_cfg($urandom_range(5, 9), $urandom_range(1, 6), 2, 1'b1);
      step(e_ser.size() - 3); cap_en = 1'b0;
      for (int i = 0; i < e_ser.size(); i++) begin
         total++;
         if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
            $display("FAIL cfg_change cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", i,
                     c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
         else passed++;
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         logic [7:0] q[$];
         int c = $urandom_range(0, 3), nb = $urandom_range(0, 9), m = $urandom_range(0, 3);
         bit s2 = 1'($urandom);
         int k = $urandom_range(1, 3);
         for (int i = 0; i < k; i++) q.push_back(8'($urandom));
         set_cfg(c, nb, m, s2);
         exp_init();
         foreach (q[i]) exp_frame(q[i], c, nb, m, s2);
         exp_idle(4);
         cap_start(); write_burst(q); step(e_ser.size() - k); cap_en = 1'b0;
         for (int i = 0; i < e_ser.size(); i++) begin
            total++;
            if ({c_ser[i], c_act[i], c_done[i], c_ovr[i]} !== {e_ser[i], e_act[i], e_done[i], e_ovr[i]})
               $display("FAIL random r%0d cyc %0d ser/act/done/ovr got %b%b%b%b want %b%b%b%b", r, i,
                        c_ser[i], c_act[i], c_done[i], c_ovr[i], e_ser[i], e_act[i], e_done[i], e_ovr[i]);
            else passed++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; dv = 1'b0; txb = '0;
      set_cfg(4, 8, 0, 1'b0);
      test_reset();
      test_8n1();
      test_7e2();
      test_parity();
      test_cfg0();
      test_overflow();
      test_reset_midframe();
      test_cfg_change();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
